// File: rtl/stk_seq_ctrl.sv
// Stack-machine instruction sequencer: fetch/decode, one-at-a-time dispatch to the
// push/pop and ALU units with a bounded fin wait, local JMP/JZ/HALT, sticky error.
module stk_seq_ctrl #(
  parameter int ADDR_LEN = 8,
  parameter int DATA_LEN = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic [ADDR_LEN-1:0]   instr_addr,
  output logic                  instr_rd,
  input  logic [DATA_LEN+3:0]   instr_data,
  output logic [3:0]            control_bus,
  output logic [DATA_LEN-1:0]   addr_const,
  output logic                  wbpb_en,
  input  logic                  wbpb_fin,
  output logic                  alu_en,
  input  logic                  alu_fin,
  input  logic                  zero_flag,
  output logic                  busy,
  output logic                  halted,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_HALT, S_ERR
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t              state, nxt;
  logic [ADDR_LEN-1:0] pc;
  logic [DATA_LEN+3:0] ir;
  logic [CW-1:0]       cnt;

  logic [3:0]          d_opc;
  logic [ADDR_LEN-1:0] d_tgt;
  logic                fin_hit;
  logic                timed_out;

  assign d_opc      = instr_data[DATA_LEN+3:DATA_LEN];
  assign d_tgt      = ADDR_LEN'(instr_data[DATA_LEN-1:0]);
  // Only the unit that owns the in-flight opcode may complete it.
  assign fin_hit    = (ir[DATA_LEN+3:DATA_LEN] < 4'd3) ? wbpb_fin : alu_fin;
  assign timed_out  = (cnt == CW'(TIMEOUT - 1));
  assign instr_addr = pc;
  assign addr_const = ir[DATA_LEN-1:0];

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (d_opc < 4'd8)                          nxt = S_EXEC;
        else if (d_opc == OP_JMP || d_opc == OP_JZ) nxt = S_FETCH;
        else if (d_opc == OP_HALT)                 nxt = S_HALT;
        else                                       nxt = S_ERR;
      end
      S_EXEC:   nxt = S_WAIT;
      S_WAIT: begin
        if (fin_hit)        nxt = S_FETCH;
        else if (timed_out) nxt = S_ERR;
      end
      S_HALT:   if (start) nxt = S_FETCH;
      default:  nxt = state;
    endcase
  end

  // Status/strobe outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      cnt         <= '0;
      control_bus <= '0;
      instr_rd    <= 1'b0;
      wbpb_en     <= 1'b0;
      alu_en      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else begin
      state    <= nxt;
      instr_rd <= (nxt == S_FETCH);
      busy     <= nxt inside {S_FETCH, S_DECODE, S_EXEC, S_WAIT};
      halted   <= (nxt == S_HALT);
      error    <= (nxt == S_ERR);
      wbpb_en  <= (nxt == S_EXEC) && (d_opc <  4'd3);
      alu_en   <= (nxt == S_EXEC) && (d_opc >= 4'd3);
      case (state)
        S_IDLE, S_HALT: if (start) pc <= '0;
        S_DECODE: begin
          ir <= instr_data;
          if (d_opc < 4'd8)        control_bus <= d_opc;
          else if (d_opc == OP_JMP) pc <= d_tgt;
          else if (d_opc == OP_JZ)  pc <= zero_flag ? d_tgt : pc + ADDR_LEN'(1);
        end
        S_EXEC: cnt <= '0;
        S_WAIT: begin
          if (fin_hit) begin
            pc          <= pc + ADDR_LEN'(1);
            control_bus <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
